// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths, FSM encoding and requester ids for the register arbiter
package i2c_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic ID_I2C  = 1'b0;
  localparam logic ID_HOST = 1'b1;

endpackage

// File: rtl/i2c_arb_starve_guard.sv
// rtl/i2c_arb_starve_guard.sv - counts back-to-back I2C grants taken while the host waits
module i2c_arb_starve_guard
  import i2c_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic host_req,
  input  logic idle,
  input  logic i2c_grant,
  input  logic host_grant,
  output logic host_force
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (host_grant || (idle && !host_req)) begin
      streak_d = '0;
    end else if (i2c_grant && host_req && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign host_force = host_req && (streak_q == STREAK_MAX);

endmodule

// File: rtl/i2c_reg_arbiter.sv
// rtl/i2c_reg_arbiter.sv - two-port arbiter in front of the single-port register RAM
module i2c_reg_arbiter
  import i2c_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = 256,
  parameter int READ_LAT   = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_gnt,
  output logic              i2c_rvalid,
  output logic [DATA_W-1:0] i2c_rdata,
  output logic              i2c_err,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic              i2c_gnt_q, i2c_gnt_d, host_gnt_q, host_gnt_d;
  logic              i2c_rvalid_q, i2c_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic              i2c_err_q, i2c_err_d, host_err_q, host_err_d;
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d, host_rdata_q, host_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              idle, host_force, pick_host, any_req;
  logic              sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_word;

  assign idle      = (state_q == ST_IDLE);
  assign any_req   = i2c_req || host_req;
  assign pick_host = host_req && (!i2c_req || host_force);
  assign sel_we    = pick_host ? host_we    : i2c_we;
  assign sel_addr  = pick_host ? host_addr  : i2c_addr;
  assign sel_wdata = pick_host ? host_wdata : i2c_wdata;
  assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_X);
  assign rd_word   = oor_q ? '0 : mem_rdata;

  i2c_arb_starve_guard #(
    .MAX_STREAK (MAX_STREAK)
  ) u_guard (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .idle       (idle),
    .i2c_grant  (idle && i2c_req && !pick_host),
    .host_grant (idle && pick_host),
    .host_force (host_force)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    we_d          = we_q;
    oor_d         = oor_q;
    i2c_rdata_d   = i2c_rdata_q;
    host_rdata_d  = host_rdata_q;
    i2c_gnt_d     = 1'b0;
    host_gnt_d    = 1'b0;
    i2c_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    i2c_err_d     = 1'b0;
    host_err_d    = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // Outputs are registered, so the ISSUE-cycle values are set up here.
          id_d        = pick_host ? ID_HOST : ID_I2C;
          we_d        = sel_we;
          oor_d       = sel_oor;
          i2c_gnt_d   = !pick_host;
          host_gnt_d  = pick_host;
          i2c_err_d   = !pick_host && sel_we && sel_oor;
          host_err_d  = pick_host && sel_we && sel_oor;
          mem_en_d    = !sel_oor;
          mem_we_d    = sel_we && !sel_oor;
          mem_addr_d  = sel_oor ? '0 : sel_addr;
          mem_wdata_d = (sel_oor || !sel_we) ? '0 : sel_wdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (id_q == ID_HOST) begin
            host_rdata_d  = rd_word;
            host_rvalid_d = 1'b1;
            host_err_d    = oor_q;
          end else begin
            i2c_rdata_d   = rd_word;
            i2c_rvalid_d  = 1'b1;
            i2c_err_d     = oor_q;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      id_q          <= ID_I2C;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      i2c_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      i2c_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      i2c_err_q     <= 1'b0;
      host_err_q    <= 1'b0;
      i2c_rdata_q   <= '0;
      host_rdata_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      we_q          <= we_d;
      oor_q         <= oor_d;
      i2c_gnt_q     <= i2c_gnt_d;
      host_gnt_q    <= host_gnt_d;
      i2c_rvalid_q  <= i2c_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      i2c_err_q     <= i2c_err_d;
      host_err_q    <= host_err_d;
      i2c_rdata_q   <= i2c_rdata_d;
      host_rdata_q  <= host_rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign i2c_gnt     = i2c_gnt_q;
  assign host_gnt    = host_gnt_q;
  assign i2c_rvalid  = i2c_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign i2c_err     = i2c_err_q;
  assign host_err    = host_err_q;
  assign i2c_rdata   = i2c_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb/tb_i2c_reg_arbiter.sv - directed vectors for the arbiter with READ_LAT=1 and READ_LAT=3 instances
module tb_i2c_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i2c_req, i2c_we, host_req, host_we;
  logic [15:0] i2c_addr, host_addr;
  logic [31:0] i2c_wdata, host_wdata;

  logic        i2c_gnt, i2c_rvalid, i2c_err, host_gnt, host_rvalid, host_err;
  logic [31:0] i2c_rdata, host_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        i2c_gnt3, i2c_rvalid3, i2c_err3, host_gnt3, host_rvalid3, host_err3;
  logic [31:0] i2c_rdata3, host_rdata3;
  logic        mem_en3, mem_we3;
  logic [15:0] mem_addr3;
  logic [31:0] mem_wdata3;
  logic [31:0] mem_rdata3;

  logic [31:0] ram [256];

  int total = 0;
  int bad = 0;

  int g_gnt, g_rv, g_err, g_men, g_other;
  logic [31:0] g_rdata;

  typedef struct packed {
    logic        host;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  assign mem_rdata3 = 32'hDEAD_BEEF;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  i2c_reg_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .READ_LAT(1), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_gnt(i2c_gnt), .i2c_rvalid(i2c_rvalid), .i2c_rdata(i2c_rdata), .i2c_err(i2c_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  i2c_reg_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .READ_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_gnt(i2c_gnt3), .i2c_rvalid(i2c_rvalid3), .i2c_rdata(i2c_rdata3), .i2c_err(i2c_err3),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt3), .host_rvalid(host_rvalid3), .host_rdata(host_rdata3), .host_err(host_err3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  wire [119:0] out_all  = {i2c_gnt, host_gnt, i2c_rvalid, host_rvalid, i2c_rdata, host_rdata,
                           i2c_err, host_err, mem_en, mem_we, mem_addr, mem_wdata};
  wire [119:0] out_all3 = {i2c_gnt3, host_gnt3, i2c_rvalid3, host_rvalid3, i2c_rdata3, host_rdata3,
                           i2c_err3, host_err3, mem_en3, mem_we3, mem_addr3, mem_wdata3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one access on the READ_LAT=1 instance, recording event cycles relative to req in cycle 0.
  task automatic access(input logic host, input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    int cyc;
    int tail;
    logic gnt, rv, err, other;
    g_gnt = -1; g_rv = -1; g_err = -1; g_men = 0; g_other = 0; g_rdata = '0;
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    end else begin
      i2c_req = 1'b1; i2c_we = we; i2c_addr = addr; i2c_wdata = wdata;
    end
    cyc = 0;
    tail = -1;
    while (cyc < 20 && tail != 0) begin
      step();
      cyc++;
      if (tail > 0) tail--;
      gnt   = host ? host_gnt    : i2c_gnt;
      rv    = host ? host_rvalid : i2c_rvalid;
      err   = host ? host_err    : i2c_err;
      other = host ? (i2c_gnt | i2c_rvalid | i2c_err) : (host_gnt | host_rvalid | host_err);
      if (gnt && g_gnt < 0) begin
        g_gnt = cyc;
        if (host) host_req = 1'b0; else i2c_req = 1'b0;
        if (we) tail = 1;
      end
      if (rv && g_rv < 0) begin
        g_rv = cyc;
        g_rdata = host ? host_rdata : i2c_rdata;
        tail = 1;
      end
      if (err && g_err < 0) g_err = cyc;
      if (mem_en) g_men++;
      if (other) g_other++;
    end
    i2c_req = 1'b0;
    host_req = 1'b0;
  endtask

  initial begin
    int ig, hg, irv, hrv, n, c, both, spurious;
    logic [9:0] order;

    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    rst = 1'b1;
    i2c_req = 0; i2c_we = 0; i2c_addr = '0; i2c_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;

    //            host  we   addr      wdata         exp_rdata     exp_err
    vecs[0] = '{1'b1, 1'b1, 16'h0004, 32'h01020304, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h0004, 32'h00000000, 32'h01020304, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h00FF, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 32'h12345678, 32'h00000000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h00FF, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h0100, 32'h00000000, 32'h00000000, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'h00FF, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 16'h0004, 32'h00000000, 32'h01020304, 1'b0};

    repeat (3) step();
    check("reset_outputs", 128'(out_all), 128'h0);
    check("reset_outputs3", 128'(out_all3), 128'h0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 9; v++) begin
      access(vecs[v].host, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      check($sformatf("v%0d_gnt_cycle", v), 128'(g_gnt), 128'(1));
      check($sformatf("v%0d_rvalid_cycle", v), 128'(g_rv), vecs[v].we ? 128'(-1) : 128'(3));
      check($sformatf("v%0d_err_cycle", v), 128'(g_err),
            !vecs[v].exp_err ? 128'(-1) : (vecs[v].we ? 128'(1) : 128'(3)));
      check($sformatf("v%0d_mem_en_count", v), 128'(g_men), vecs[v].exp_err ? 128'(0) : 128'(1));
      check($sformatf("v%0d_other_port_quiet", v), 128'(g_other), 128'(0));
      if (!vecs[v].we) check($sformatf("v%0d_rdata", v), 128'(g_rdata), 128'(vecs[v].exp_rdata));
    end
    check("i2c_rdata_held", 128'(i2c_rdata), 128'h0CAFEF00D);

    // Simultaneous requests: I2C read goes first, host write follows the I2C RESP.
    i2c_req = 1; i2c_we = 0; i2c_addr = 16'h0000; i2c_wdata = '0;
    host_req = 1; host_we = 1; host_addr = 16'h0001; host_wdata = 32'hA5A5A5A5;
    ig = -1; hg = -1; irv = -1;
    for (int cy = 1; cy <= 12; cy++) begin
      step();
      if (i2c_gnt) begin if (ig < 0) ig = cy; i2c_req = 0; end
      if (host_gnt) begin if (hg < 0) hg = cy; host_req = 0; end
      if (i2c_rvalid && irv < 0) irv = cy;
    end
    check("sim_i2c_gnt_cycle", 128'(ig), 128'(1));
    check("sim_i2c_rvalid_cycle", 128'(irv), 128'(3));
    check("sim_host_gnt_cycle", 128'(hg), 128'(5));
    check("sim_i2c_rdata", 128'(i2c_rdata), 128'h0);
    access(1'b0, 1'b0, 16'h0001, 32'h0);
    check("sim_host_write_landed", 128'(g_rdata), 128'hA5A5A5A5);

    // Both requesters saturate the bus with writes; host gets every fifth grant.
    i2c_req = 1; i2c_we = 1; i2c_addr = 16'h0010; i2c_wdata = 32'h1;
    host_req = 1; host_we = 1; host_addr = 16'h0011; host_wdata = 32'h2;
    order = '0; n = 0; c = 0; both = 0;
    while (n < 10 && c < 60) begin
      step();
      c++;
      if (i2c_gnt && host_gnt) both++;
      if (i2c_gnt || host_gnt) begin
        order[n] = host_gnt;
        n++;
      end
    end
    i2c_req = 0; host_req = 0;
    step(); step();
    check("streak_grant_count", 128'(n), 128'(10));
    check("streak_grant_order", 128'(order), 128'(10'b1000010000));
    check("streak_no_double_gnt", 128'(both), 128'(0));

    // Reset during WAIT of a READ_LAT=3 read aborts it.
    rst = 1; step(); rst = 0;
    i2c_req = 1; i2c_we = 0; i2c_addr = 16'h0002;
    step();
    check("rst3_first_gnt", 128'(i2c_gnt3), 128'(1));
    i2c_req = 0;
    step();
    rst = 1;
    step();
    check("rst3_outputs_zero", 128'(out_all3), 128'h0);
    rst = 0;
    spurious = 0;
    repeat (8) begin
      step();
      if (i2c_rvalid3 | i2c_err3 | i2c_gnt3 | host_gnt3 | host_rvalid3 | host_err3) spurious++;
    end
    check("rst3_no_late_pulse", 128'(spurious), 128'(0));
    host_req = 1; host_we = 0; host_addr = 16'h0003;
    hg = -1; hrv = -1;
    for (int cy = 1; cy <= 10; cy++) begin
      step();
      if (host_gnt3) begin if (hg < 0) hg = cy; host_req = 0; end
      if (host_rvalid3 && hrv < 0) hrv = cy;
    end
    check("rst3_next_gnt_cycle", 128'(hg), 128'(1));
    check("rst3_next_rvalid_cycle", 128'(hrv), 128'(5));
    check("rst3_next_rdata", 128'(host_rdata3), 128'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
